w_dpr_writer: RTL and testbench

//   Write-side companion of the W-buffer read address generator. Accepts the word stream read out of

---
 rtl/w_dpr_writer.sv | 131 +++++++++++++
 tb/tb_w_dpr_writer.sv | 170 +++++++++++++++++
 2 files changed

// File: rtl/w_dpr_writer.sv
// Scatters the temp_buff word stream into the P W_i dual-port RAMs.
// Word order: m fastest, then DPR index p, then gamma block; local address = gamma*M + m.
module w_dpr_writer #(
    parameter int DATA_W       = 8,
    parameter int FEATURE_BITS = 4,
    parameter int P            = 4,
    parameter int M            = 9,
    parameter int GAMMA        = 3
) (
    input  logic                      sys_clk,
    input  logic                      reset_n,
    input  logic                      start,
    input  logic                      in_valid,
    input  logic [DATA_W-1:0]         in_data,
    output logic [P-1:0]              wr_en,
    output logic [2*FEATURE_BITS-1:0] wr_addr,
    output logic [DATA_W-1:0]         wr_data,
    output logic                      busy,
    output logic                      done,
    output logic                      err_extra
);

    // state  | meaning
    // S_IDLE | after reset, waiting for start
    // S_RUN  | accepting words, one per in_valid cycle
    // S_DONE | final word written, waiting for next start

    localparam int AW = 2 * FEATURE_BITS;
    localparam int MW = (M > 1) ? $clog2(M) : 1;
    localparam int PW = (P > 1) ? $clog2(P) : 1;
    localparam int GW = (GAMMA > 1) ? $clog2(GAMMA) : 1;

    typedef enum logic [1:0] {S_IDLE, S_RUN, S_DONE} state_t;

    state_t            r_state, w_state_nxt;
    logic [MW-1:0]     r_m, w_m_nxt;
    logic [PW-1:0]     r_p, w_p_nxt;
    logic [GW-1:0]     r_gamma, w_gamma_nxt;
    logic [AW-1:0]     r_base, w_base_nxt;
    logic [P-1:0]      r_wr_en, w_wr_en_nxt;
    logic [AW-1:0]     r_wr_addr, w_wr_addr_nxt;
    logic [DATA_W-1:0] r_wr_data, w_wr_data_nxt;
    logic              r_err_extra, w_err_extra_nxt;
    logic              w_m_wrap, w_p_wrap, w_last;

    assign w_m_wrap = (r_m == MW'(M - 1));
    assign w_p_wrap = (r_p == PW'(P - 1));
    assign w_last   = w_m_wrap && w_p_wrap && (r_gamma == GW'(GAMMA - 1));

    always_comb begin
        w_state_nxt     = r_state;
        w_m_nxt         = r_m;
        w_p_nxt         = r_p;
        w_gamma_nxt     = r_gamma;
        w_base_nxt      = r_base;
        w_wr_en_nxt     = '0;
        w_wr_addr_nxt   = r_wr_addr;
        w_wr_data_nxt   = r_wr_data;
        w_err_extra_nxt = 1'b0;

        case (r_state)
            S_RUN: begin
                if (in_valid) begin
                    for (int i = 0; i < P; i++) begin
                        w_wr_en_nxt[i] = (r_p == PW'(i));
                    end
                    w_wr_addr_nxt = r_base + AW'(r_m);
                    w_wr_data_nxt = in_data;
                    if (w_m_wrap) begin
                        w_m_nxt = '0;
                        if (w_p_wrap) begin
                            w_p_nxt     = '0;
                            w_gamma_nxt = r_gamma + GW'(1);
                            w_base_nxt  = r_base + AW'(M);
                        end else begin
                            w_p_nxt = r_p + PW'(1);
                        end
                    end else begin
                        w_m_nxt = r_m + MW'(1);
                    end
                    if (w_last) begin
                        w_state_nxt = S_DONE;
                    end
                end
            end
            default: begin
                // Words outside RUN are dropped, even alongside start.
                w_err_extra_nxt = in_valid;
                if (start) begin
                    w_state_nxt = S_RUN;
                    w_m_nxt     = '0;
                    w_p_nxt     = '0;
                    w_gamma_nxt = '0;
                    w_base_nxt  = '0;
                end
            end
        endcase
    end

    always_ff @(posedge sys_clk or negedge reset_n) begin
        if (!reset_n) begin
            r_state     <= S_IDLE;
            r_m         <= '0;
            r_p         <= '0;
            r_gamma     <= '0;
            r_base      <= '0;
            r_wr_en     <= '0;
            r_wr_addr   <= '0;
            r_wr_data   <= '0;
            r_err_extra <= 1'b0;
        end else begin
            r_state     <= w_state_nxt;
            r_m         <= w_m_nxt;
            r_p         <= w_p_nxt;
            r_gamma     <= w_gamma_nxt;
            r_base      <= w_base_nxt;
            r_wr_en     <= w_wr_en_nxt;
            r_wr_addr   <= w_wr_addr_nxt;
            r_wr_data   <= w_wr_data_nxt;
            r_err_extra <= w_err_extra_nxt;
        end
    end

    assign wr_en     = r_wr_en;
    assign wr_addr   = r_wr_addr;
    assign wr_data   = r_wr_data;
    assign err_extra = r_err_extra;
    assign busy      = (r_state == S_RUN);
    assign done      = (r_state == S_DONE);

endmodule

// File: tb/tb_w_dpr_writer.sv
// Bench for w_dpr_writer: directed steps, expected writes queued at drive time
// and popped after the capturing edge; a second 1x1x1 instance covers the degenerate case.
module tb_w_dpr_writer;

    localparam int P = 4, M = 9, GAMMA = 3, TOTAL = P * M * GAMMA;

    logic       sys_clk = 1'b0;
    logic       reset_n = 1'b0;
    logic       start = 1'b0, in_valid = 1'b0;
    logic [7:0] in_data = '0;
    logic [3:0] wr_en;
    logic [7:0] wr_addr, wr_data;
    logic       busy, done, err_extra;

    logic       s_start = 1'b0, s_valid = 1'b0;
    logic [7:0] s_data = '0;
    logic [0:0] s_wr_en;
    logic [7:0] s_wr_addr, s_wr_data;
    logic       s_busy, s_done, s_err;

    int errors = 0, checks = 0;
    int mstate = 0;
    int k = 0;

    typedef struct {
        logic [3:0] en;
        logic [7:0] addr;
        logic [7:0] data;
        logic       err, busy, done;
    } exp_t;
    exp_t sb[$];

    always #5 sys_clk = ~sys_clk;

    w_dpr_writer dut (
        .sys_clk(sys_clk), .reset_n(reset_n), .start(start), .in_valid(in_valid),
        .in_data(in_data), .wr_en(wr_en), .wr_addr(wr_addr), .wr_data(wr_data),
        .busy(busy), .done(done), .err_extra(err_extra)
    );

    w_dpr_writer #(.DATA_W(8), .FEATURE_BITS(4), .P(1), .M(1), .GAMMA(1)) dut_s (
        .sys_clk(sys_clk), .reset_n(reset_n), .start(s_start), .in_valid(s_valid),
        .in_data(s_data), .wr_en(s_wr_en), .wr_addr(s_wr_addr), .wr_data(s_wr_data),
        .busy(s_busy), .done(s_done), .err_extra(s_err)
    );

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] expv);
        checks++;
        assert (obs === expv) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, expv);
        end
    endtask

    // Model: word k goes to DPR (k/M)%P at address (k/(M*P))*M + k%M.
    task automatic step(input logic s, input logic v, input logic [7:0] d);
        exp_t e;
        e.en = '0; e.addr = '0; e.data = '0; e.err = 1'b0;
        if (mstate == 1) begin
            if (v) begin
                e.en   = 4'(1) << ((k / M) % P);
                e.addr = 8'((k / (M * P)) * M + (k % M));
                e.data = d;
                k++;
                if (k == TOTAL) mstate = 2;
            end
        end else begin
            e.err = v;
            if (s) begin
                mstate = 1;
                k = 0;
            end
        end
        e.busy = (mstate == 1);
        e.done = (mstate == 2);
        sb.push_back(e);
        start = s; in_valid = v; in_data = d;
        @(posedge sys_clk); #1;
        start = 1'b0; in_valid = 1'b0;
        e = sb.pop_front();
        chk("wr_en", 32'(wr_en), 32'(e.en));
        if (e.en != 0) begin
            chk("wr_addr", 32'(wr_addr), 32'(e.addr));
            chk("wr_data", 32'(wr_data), 32'(e.data));
        end
        chk("err_extra", 32'(err_extra), 32'(e.err));
        chk("busy", 32'(busy), 32'(e.busy));
        chk("done", 32'(done), 32'(e.done));
    endtask

    task automatic check_reset_outputs(input string tag);
        chk({tag, "_wr_en"}, 32'(wr_en), 32'd0);
        chk({tag, "_wr_addr"}, 32'(wr_addr), 32'd0);
        chk({tag, "_wr_data"}, 32'(wr_data), 32'd0);
        chk({tag, "_busy"}, 32'(busy), 32'd0);
        chk({tag, "_done"}, 32'(done), 32'd0);
        chk({tag, "_err"}, 32'(err_extra), 32'd0);
    endtask

    initial begin
        // Reset state
        #3;
        check_reset_outputs("rst0");
        #10 reset_n = 1'b1;
        @(posedge sys_clk); #1;

        // T1: back-to-back full transfer
        step(1'b1, 1'b0, 8'd0);
        for (int i = 0; i < TOTAL; i++) step(1'b0, 1'b1, 8'(i));

        // T3: stray words after done, then restart (start+valid word is dropped)
        for (int i = 0; i < 3; i++) step(1'b0, 1'b1, 8'(200 + i));
        step(1'b1, 1'b1, 8'd99);
        // T5: start pulse mid-run at word 20 is ignored
        for (int i = 0; i < TOTAL; i++) step(i == 20, 1'b1, 8'(i));

        // T2: random in_valid gaps
        step(1'b1, 1'b0, 8'd0);
        begin
            int n = 0;
            for (int it = 0; it < 1000 && n < TOTAL; it++) begin
                logic v;
                v = ($urandom_range(0, 2) != 0);
                step(1'b0, v, 8'(n));
                if (v) n++;
            end
            chk("t2_word_count", 32'(n), 32'(TOTAL));
        end

        // T4: async reset after 50 words, then a full clean transfer
        step(1'b1, 1'b0, 8'd0);
        for (int i = 0; i < 50; i++) step(1'b0, 1'b1, 8'(i));
        #2 reset_n = 1'b0;
        #1;
        check_reset_outputs("rst_mid");
        mstate = 0; k = 0; sb.delete();
        @(posedge sys_clk); #1;
        chk("rst_hold_wr_en", 32'(wr_en), 32'd0);
        #2 reset_n = 1'b1;
        @(posedge sys_clk); #1;
        step(1'b0, 1'b1, 8'd77);
        step(1'b1, 1'b0, 8'd0);
        for (int i = 0; i < TOTAL; i++) step(1'b0, 1'b1, 8'(255 - i));

        // T6: P=1, M=1, GAMMA=1 instance
        s_start = 1'b1;
        @(posedge sys_clk); #1;
        s_start = 1'b0;
        chk("t6_busy_after_start", 32'(s_busy), 32'd1);
        chk("t6_idle_wr_en", 32'(s_wr_en), 32'd0);
        s_valid = 1'b1; s_data = 8'h5A;
        @(posedge sys_clk); #1;
        s_valid = 1'b0;
        chk("t6_wr_en", 32'(s_wr_en), 32'd1);
        chk("t6_wr_addr", 32'(s_wr_addr), 32'd0);
        chk("t6_wr_data", 32'(s_wr_data), 32'h5A);
        chk("t6_done", 32'(s_done), 32'd1);
        chk("t6_busy", 32'(s_busy), 32'd0);
        s_valid = 1'b1; s_data = 8'h11;
        @(posedge sys_clk); #1;
        s_valid = 1'b0;
        chk("t6_extra_wr_en", 32'(s_wr_en), 32'd0);
        chk("t6_extra_err", 32'(s_err), 32'd1);
        chk("t6_extra_done", 32'(s_done), 32'd1);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
